// File: rtl/controller_pipe.sv
// Pipelined control unit: decodes an opcode into a control bundle and carries
// it, with valid bit and write-destination, through DEPTH registered stages.

module controller_pipe_stage #(
  parameter int BW    = 20,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d_valid,
  input  logic [BW-1:0]    d_ctrl,
  input  logic [REG_W-1:0] d_dest,
  output logic             q_valid,
  output logic [BW-1:0]    q_ctrl,
  output logic [REG_W-1:0] q_dest
);

  // A bubble always carries an all-zero payload, whatever the upstream drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_dest  <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q_ctrl  <= d_valid ? d_ctrl : '0;
      q_dest  <= d_valid ? d_dest : '0;
    end
  end

endmodule

module controller_pipe #(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 6,
  parameter int REG_W       = 5,
  parameter int DEPTH       = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic [OP_WIDTH-1:0]                  opcode,
  input  logic [REG_W-1:0]                     rs,
  input  logic [REG_W-1:0]                     rt,
  input  logic [REG_W-1:0]                     rd,
  input  logic                                 flush,
  input  logic                                 stall_ext,
  output logic [ALUOP_WIDTH+13:0]              id_ctrl,
  output logic [DEPTH*(ALUOP_WIDTH+14)-1:0]    stage_ctrl,
  output logic [DEPTH-1:0]                     stage_valid,
  output logic [DEPTH*REG_W-1:0]               stage_dest,
  output logic                                 hazard_stall
);

  localparam int BW = ALUOP_WIDTH + 14;

  // Bundle bit positions (LSB side); ALUop sits above B_REGWRITE.
  localparam int B_REGWRITE = 13;
  localparam int B_MEMREAD  = 4;

  logic [31:0]            op;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic                   reg_write, reg_dest, mem_to_reg, is_signed, alu_src;
  logic                   jump, jal, branch, eq, mem_read, mem_write, mem_is_signed;
  logic [1:0]             mem_size;
  logic [REG_W-1:0]       id_dest;

  assign op = 32'(opcode);

  always_comb begin
    alu_op        = ALUOP_WIDTH'(opcode);
    reg_write     = 1'b0;
    reg_dest      = 1'b0;
    mem_to_reg    = 1'b0;
    is_signed     = 1'b0;
    alu_src       = 1'b0;
    jump          = 1'b0;
    jal           = 1'b0;
    branch        = 1'b0;
    eq            = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_is_signed = 1'b0;
    mem_size      = 2'd0;
    case (op)
      32'h00: begin
        alu_op    = '0;
        reg_write = 1'b1;
        reg_dest  = 1'b1;
      end
      32'h02: jump = 1'b1;
      32'h03: begin
        jump      = 1'b1;
        jal       = 1'b1;
        reg_write = 1'b1;
      end
      32'h04: begin
        branch = 1'b1;
        eq     = 1'b1;
      end
      32'h05: branch = 1'b1;
      32'h08, 32'h09, 32'h0A, 32'h0B, 32'h0C, 32'h0D, 32'h0E, 32'h0F: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        is_signed = (op == 32'h08) || (op == 32'h0A);
      end
      32'h20, 32'h21, 32'h23, 32'h24, 32'h25: begin
        mem_read      = 1'b1;
        mem_to_reg    = 1'b1;
        reg_write     = 1'b1;
        alu_src       = 1'b1;
        is_signed     = 1'b1;
        mem_is_signed = (op == 32'h20) || (op == 32'h21);
        mem_size      = (op == 32'h23) ? 2'd2 :
                        (op == 32'h21 || op == 32'h25) ? 2'd1 : 2'd0;
      end
      32'h28, 32'h29, 32'h2B: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        is_signed = 1'b1;
        mem_size  = (op == 32'h2B) ? 2'd2 : (op == 32'h29) ? 2'd1 : 2'd0;
      end
      default: alu_op = '0;
    endcase
  end

  assign id_ctrl = {alu_op, reg_write, reg_dest, mem_to_reg, is_signed, alu_src,
                    jump, jal, branch, eq, mem_read, mem_write, mem_is_signed,
                    mem_size};

  always_comb begin
    id_dest = rt;
    if (!reg_write)   id_dest = '0;
    else if (reg_dest) id_dest = rd;
    else if (jal)      id_dest = REG_W'(31);
  end

  // Index 0 is what stage 0 would load this cycle; index k+1 is stage k.
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][BW-1:0]    ctrl_pipe;
  logic [DEPTH:0][REG_W-1:0] dest_pipe;
  logic                      load0;

  assign load0        = id_valid & ~flush & ~hazard_stall;
  assign vld_pipe[0]  = load0;
  assign ctrl_pipe[0] = load0 ? id_ctrl : '0;
  assign dest_pipe[0] = load0 ? id_dest : '0;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      controller_pipe_stage #(
        .BW    (BW),
        .REG_W (REG_W)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (~stall_ext),
        .d_valid (vld_pipe[g]),
        .d_ctrl  (ctrl_pipe[g]),
        .d_dest  (dest_pipe[g]),
        .q_valid (vld_pipe[g+1]),
        .q_ctrl  (ctrl_pipe[g+1]),
        .q_dest  (dest_pipe[g+1])
      );
    end
  endgenerate

  // Load-use: a load in stage 0 whose result the decode-stage instruction names.
  assign hazard_stall = id_valid & vld_pipe[1] & ctrl_pipe[1][B_MEMREAD] &
                        (dest_pipe[1] != '0) &
                        ((dest_pipe[1] == rs) | (dest_pipe[1] == rt));

  assign stage_valid = vld_pipe[DEPTH:1];
  assign stage_ctrl  = ctrl_pipe[DEPTH:1];
  assign stage_dest  = dest_pipe[DEPTH:1];

endmodule

// File: tb/tb_controller_pipe.sv
// Directed bench for controller_pipe: decode table, load-use, flush, external
// stall, async reset, and DEPTH=2/6 instances.

module tb_controller_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, flush, stall_ext;
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;

  logic [19:0]  id_ctrl, id_ctrl2, id_ctrl6;
  logic [59:0]  stage_ctrl;
  logic [2:0]   stage_valid;
  logic [14:0]  stage_dest;
  logic         hazard_stall;
  logic [39:0]  stage_ctrl2;
  logic [1:0]   stage_valid2;
  logic [9:0]   stage_dest2;
  logic         hazard_stall2;
  logic [119:0] stage_ctrl6;
  logic [5:0]   stage_valid6;
  logic [29:0]  stage_dest6;
  logic         hazard_stall6;

  int vectors = 0;
  int errors  = 0;

  localparam logic [19:0] C_ADD = 20'h03000;
  localparam logic [19:0] C_JAL = 20'h0E180;
  localparam logic [19:0] C_LW  = 20'h8EE12;
  localparam logic [19:0] C_LB  = 20'h82E14;
  localparam logic [19:0] C_ADDI = 20'h22600;
  localparam logic [19:0] C_ORI = 20'h36200;

  controller_pipe #(.DEPTH(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .flush(flush), .stall_ext(stall_ext), .id_ctrl(id_ctrl),
    .stage_ctrl(stage_ctrl), .stage_valid(stage_valid), .stage_dest(stage_dest),
    .hazard_stall(hazard_stall));

  controller_pipe #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .flush(flush), .stall_ext(stall_ext), .id_ctrl(id_ctrl2),
    .stage_ctrl(stage_ctrl2), .stage_valid(stage_valid2), .stage_dest(stage_dest2),
    .hazard_stall(hazard_stall2));

  controller_pipe #(.DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .flush(flush), .stall_ext(stall_ext), .id_ctrl(id_ctrl6),
    .stage_ctrl(stage_ctrl6), .stage_valid(stage_valid6), .stage_dest(stage_dest6),
    .hazard_stall(hazard_stall6));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic v, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d);
    opcode = op; id_valid = v; rs = s; rt = t; rd = d;
  endtask

  task automatic drain;
    drive(6'h00, 1'b0, 5'd0, 5'd0, 5'd0);
    flush = 1'b0; stall_ext = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; stall_ext = 1'b0;
    drive(6'h00, 1'b1, 5'd1, 5'd2, 5'd3);
    #2;
    vectors++;
    if (stage_valid !== 3'b000 || stage_ctrl !== '0 || stage_dest !== '0 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: valid=%b ctrl=%h dest=%h hz=%b, need all 0", stage_valid, stage_ctrl, stage_dest, hazard_stall);
    end
    tick(); tick();
    vectors++;
    if (stage_valid !== 3'b000 || stage_ctrl !== '0 || stage_valid6 !== 6'd0) begin
      errors++;
      $display("FAIL reset_held: valid=%b ctrl=%h valid6=%b, need 0", stage_valid, stage_ctrl, stage_valid6);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode;
    logic [5:0]  ops [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h2B, 6'h25, 6'h3F, 6'h20, 6'h23};
    logic [19:0] ctl [12] = '{20'h03000, 20'h08100, 20'h0E180, 20'h10060, 20'h14040, 20'h22600,
                              20'h36200, 20'hAC60A, 20'h96E11, 20'h00000, 20'h82E14, 20'h8EE12};
    logic [4:0]  dst [12] = '{5'd3, 5'd0, 5'd31, 5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd2, 5'd0, 5'd2, 5'd2};
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], 1'b1, 5'd1, 5'd2, 5'd3);
      #1;
      vectors++;
      if (id_ctrl !== ctl[i]) begin
        errors++;
        $display("FAIL decode_id op=%h: got %h want %h", ops[i], id_ctrl, ctl[i]);
      end
      tick();
      vectors++;
      if (stage_valid[0] !== 1'b1 || stage_ctrl[19:0] !== ctl[i] || stage_dest[4:0] !== dst[i]) begin
        errors++;
        $display("FAIL decode_s0 op=%h: v=%b ctrl=%h dest=%0d want 1 %h %0d", ops[i], stage_valid[0], stage_ctrl[19:0], stage_dest[4:0], ctl[i], dst[i]);
      end
      id_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_jal;
    drain();
    drive(6'h03, 1'b1, 5'd1, 5'd2, 5'd3);
    tick();
    id_valid = 1'b0;
    vectors++;
    if (stage_valid !== 3'b001 || stage_ctrl[19:0] !== C_JAL || stage_dest[4:0] !== 5'd31) begin
      errors++;
      $display("FAIL jal_s0: v=%b ctrl=%h dest=%0d", stage_valid, stage_ctrl[19:0], stage_dest[4:0]);
    end
    tick();
    tick();
    vectors++;
    if (stage_valid !== 3'b100 || stage_ctrl[59:40] !== C_JAL || stage_dest[14:10] !== 5'd31 || stage_ctrl[39:0] !== '0) begin
      errors++;
      $display("FAIL jal_s2: v=%b ctrl=%h dest=%h", stage_valid, stage_ctrl, stage_dest);
    end
  endtask

  task automatic test_load_use;
    drain();
    drive(6'h23, 1'b1, 5'd0, 5'd8, 5'd0);
    tick();
    drive(6'h00, 1'b1, 5'd8, 5'd9, 5'd10);
    #1;
    vectors++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_hz: got %b want 1", hazard_stall);
    end
    tick();
    vectors++;
    if (stage_valid !== 3'b010 || stage_ctrl[19:0] !== '0 || stage_ctrl[39:20] !== C_LW || stage_dest[9:5] !== 5'd8 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: v=%b ctrl=%h dest=%h hz=%b", stage_valid, stage_ctrl, stage_dest, hazard_stall);
    end
    tick();
    vectors++;
    if (stage_valid !== 3'b101 || stage_ctrl[19:0] !== C_ADD || stage_dest[4:0] !== 5'd10 || stage_ctrl[59:40] !== C_LW) begin
      errors++;
      $display("FAIL load_use_resume: v=%b ctrl=%h dest=%h", stage_valid, stage_ctrl, stage_dest);
    end
  endtask

  task automatic test_flush;
    drain();
    drive(6'h08, 1'b1, 5'd1, 5'd4, 5'd0);
    tick();
    drive(6'h0D, 1'b1, 5'd1, 5'd5, 5'd0);
    tick();
    drive(6'h04, 1'b1, 5'd1, 5'd2, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    vectors++;
    if (stage_valid !== 3'b110 || stage_ctrl[19:0] !== '0 || stage_ctrl[39:20] !== C_ORI || stage_ctrl[59:40] !== C_ADDI ||
        stage_dest !== {5'd4, 5'd5, 5'd0}) begin
      errors++;
      $display("FAIL flush: v=%b ctrl=%h dest=%h", stage_valid, stage_ctrl, stage_dest);
    end
  endtask

  task automatic test_stall_ext;
    drain();
    drive(6'h08, 1'b1, 5'd1, 5'd4, 5'd0);
    tick();
    drive(6'h23, 1'b1, 5'd0, 5'd8, 5'd0);
    tick();
    drive(6'h00, 1'b1, 5'd8, 5'd9, 5'd10);
    flush = 1'b1; stall_ext = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (hazard_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_hz cyc%0d: got %b want 1", i, hazard_stall);
      end
      tick();
      vectors++;
      if (stage_valid !== 3'b011 || stage_ctrl[19:0] !== C_LW || stage_ctrl[39:20] !== C_ADDI || stage_dest[9:0] !== {5'd4, 5'd8}) begin
        errors++;
        $display("FAIL stall_frozen cyc%0d: v=%b ctrl=%h dest=%h", i, stage_valid, stage_ctrl, stage_dest);
      end
    end
    flush = 1'b0; stall_ext = 1'b0;
    tick();
    vectors++;
    if (stage_valid !== 3'b110 || stage_ctrl[39:20] !== C_LW || stage_ctrl[59:40] !== C_ADDI) begin
      errors++;
      $display("FAIL stall_release: v=%b ctrl=%h", stage_valid, stage_ctrl);
    end
    tick();
    vectors++;
    if (stage_valid !== 3'b101 || stage_ctrl[19:0] !== C_ADD || stage_dest[4:0] !== 5'd10) begin
      errors++;
      $display("FAIL stall_add_enters: v=%b ctrl=%h dest=%h", stage_valid, stage_ctrl, stage_dest);
    end
  endtask

  task automatic test_reset_mid;
    drive(6'h23, 1'b1, 5'd0, 5'd7, 5'd0);
    tick();
    drive(6'h00, 1'b1, 5'd7, 5'd9, 5'd10);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (stage_valid !== 3'b000 || stage_ctrl !== '0 || stage_dest !== '0 || hazard_stall !== 1'b0 || stage_valid6 !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid: v=%b ctrl=%h dest=%h hz=%b v6=%b", stage_valid, stage_ctrl, stage_dest, hazard_stall, stage_valid6);
    end
    #1;
    rst = 1'b0;
    tick();
    vectors++;
    if (stage_valid !== 3'b001 || stage_ctrl[19:0] !== C_ADD || stage_dest[4:0] !== 5'd10) begin
      errors++;
      $display("FAIL reset_first_edge: v=%b ctrl=%h dest=%h", stage_valid, stage_ctrl, stage_dest);
    end
  endtask

  task automatic test_sweep;
    drain();
    drive(6'h20, 1'b1, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (stage_valid2 !== 2'b11 || stage_valid6 !== 6'h3F || hazard_stall6 !== 1'b0) begin
      errors++;
      $display("FAIL sweep_lb_valid: v2=%b v6=%b hz6=%b", stage_valid2, stage_valid6, hazard_stall6);
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (stage_ctrl2[k*20 +: 20] !== C_LB) begin
        errors++;
        $display("FAIL sweep_lb_d2 s%0d: got %h want %h", k, stage_ctrl2[k*20 +: 20], C_LB);
      end
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (stage_ctrl6[k*20+2] !== 1'b1 || stage_ctrl6[k*20 +: 2] !== 2'd0 || stage_ctrl6[k*20 +: 20] !== C_LB) begin
        errors++;
        $display("FAIL sweep_lb_d6 s%0d: got %h want %h", k, stage_ctrl6[k*20 +: 20], C_LB);
      end
    end
    drive(6'h3F, 1'b1, 5'd1, 5'd2, 5'd3);
    #1;
    vectors++;
    if (id_ctrl2 !== 20'h0 || id_ctrl6 !== 20'h0) begin
      errors++;
      $display("FAIL sweep_3f_id: d2=%h d6=%h want 0", id_ctrl2, id_ctrl6);
    end
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (stage_valid6 !== 6'h3F || stage_ctrl6 !== '0 || stage_dest6 !== '0 || stage_valid2 !== 2'b11 || stage_ctrl2 !== '0) begin
      errors++;
      $display("FAIL sweep_3f_stages: v6=%b c6=%h d6=%h v2=%b c2=%h", stage_valid6, stage_ctrl6, stage_dest6, stage_valid2, stage_ctrl2);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_jal();
    test_load_use();
    test_flush();
    test_stall_ext();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/controller_pipe.md
CONTROLLER_PIPE -- requirements
Module: controller_pipe

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 6, opcode width.
REQ-002 SHALL have parameter ALUOP_WIDTH, default 6, ALU operation field width.
REQ-003 SHALL have parameter REG_W, default 5, register-address width.
REQ-004 SHALL have parameter DEPTH, default 3, number of registered control stages after decode (EX, MEM, WB, ...); legal range 2..6.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 id_valid  in  1  decode-stage instruction valid.
REQ-009 opcode  in  OP_WIDTH  decode-stage opcode.
REQ-010 rs, rt  in  REG_W each  decode-stage source register addresses.
REQ-011 rd  in  REG_W  R-type destination address.
REQ-012 flush  in  1  branch/jump taken; kill decode-stage instruction.
REQ-013 stall_ext  in  1  external (memory) stall; freeze all stages.
REQ-014 id_ctrl  out  ALUOP_WIDTH+14  combinational decoded bundle for decode stage.
REQ-015 stage_ctrl  out  DEPTH*(ALUOP_WIDTH+14)  registered bundles, stage k at slice k.
REQ-016 stage_valid  out  DEPTH  per-stage valid bits.
REQ-017 stage_dest  out  DEPTH*REG_W  per-stage write-destination address.
REQ-018 hazard_stall  out  1  load-use stall request to fetch/decode.

Function
REQ-019 Bundle bit order MSB to LSB SHALL be {ALUop, regWrite, regDest, memToReg, isSigned, ALUsrc, jump, jal, branch, eq, memRead, memWrite, memIsSigned, memDataSize[1:0]}.
REQ-020 Decode SHALL be: 0x00 R-type regWrite=1, regDest=1, ALUop=0; 0x02 jump=1; 0x03 jump=1, jal=1, regWrite=1; 0x04 branch=1, eq=1; 0x05 branch=1, eq=0; 0x08-0x0F regWrite=1, ALUsrc=1, isSigned=1 for 0x08/0x0A only; loads 0x20/0x21/0x23/0x24/0x25 memRead=1, memToReg=1, regWrite=1, ALUsrc=1, isSigned=1; stores 0x28/0x29/0x2B memWrite=1, ALUsrc=1, isSigned=1.
REQ-021 ALUop SHALL equal opcode zero-extended or truncated to ALUOP_WIDTH for non-R-type; memDataSize SHALL be 0 byte, 1 half, 2 word; memIsSigned=1 for 0x20, 0x21 only.
REQ-022 Unlisted opcodes SHALL decode to an all-zero bundle.
REQ-023 Decode-stage dest SHALL be rd if regDest, 31 if jal, else rt; dest forced to 0 when regWrite=0.
REQ-024 Each cycle with no stall SHALL shift stage k into stage k+1, stage 0 loading from decode; latency decode to stage k is k+1 cycles.
REQ-025 hazard_stall SHALL be 1 combinationally when id_valid, stage 0 valid, stage 0 memRead=1, stage 0 dest != 0, and dest equals rs or rt.
REQ-026 On hazard_stall (stall_ext=0), stage 0 SHALL load a bubble (valid=0, bundle=0, dest=0) while stages 1..DEPTH-1 advance.
REQ-027 On flush (stall_ext=0), stage 0 SHALL load a bubble regardless of hazard; flush has priority over hazard_stall.
REQ-028 stall_ext=1 SHALL hold all stages unchanged and override flush and hazard; hazard_stall output still reflects REQ-025.
REQ-029 id_valid=0 SHALL load a bubble into stage 0.
REQ-030 Invalid stages SHALL always present all-zero bundle and dest.

Reset
REQ-031 rst=1 SHALL clear immediately all stage_valid, stage_ctrl, stage_dest to 0 regardless of clk; hazard_stall becomes 0 since stage 0 is invalid.
REQ-032 First edge after rst deasserts SHALL load stage 0 normally.

Verification
REQ-033 lw (0x23, rt=8) then add (rs=8) with DEPTH=3 -> hazard_stall=1 one cycle, stage 0 bubble, add enters stage 0 next cycle, hazard_stall=0.
REQ-034 jal (0x03) valid -> stage 0 bundle jump=1, jal=1, regWrite=1, dest=31; reaches stage 2 after 3 cycles.
REQ-035 beq in decode with flush=1 -> stage 0 valid=0 next cycle, stages 1..2 advance.
REQ-036 stall_ext=1 for 4 cycles with flush=1 and lw/use pair -> all stages frozen, no bubble inserted, resumes shifting on release.
REQ-037 rst pulsed mid-stream between clock edges -> all outputs 0 before next edge.
REQ-038 Sweep DEPTH=2 and 6, opcode 0x3F and lb 0x20 -> all-zero bundle for 0x3F; lb memIsSigned=1, memDataSize=0 at every stage slice.
